// File: rtl/double_dabble_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package double_dabble_pkg;

    typedef enum logic {
        REPOSO    = 1'b0,
        CONVIERTE = 1'b1
    } estado_t;

    localparam int ANCHO_DIGITO = 4;

    // Counter must hold the value ANCHO itself, hence ANCHO+1 states.
    function automatic int ancho_contador(input int ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/double_dabble_secuencial_ajuste.sv
// One BCD digit correction step of double dabble: add 3 when the digit is 5 or more.
module ajuste_bcd_digito
    import double_dabble_pkg::*;
(
    input  logic [ANCHO_DIGITO-1:0] digito,
    output logic [ANCHO_DIGITO-1:0] ajustado
);

    always_comb begin
        ajustado = digito;
        if (digito >= 4'd5) begin
            ajustado = digito + 4'd3;
        end
    end

endmodule

// File: rtl/double_dabble_secuencial.sv
// Iterative binary-to-BCD converter: one operand bit per clock, start/done handshake,
// result truncated to DIGITOS digits with an overflow flag.
module double_dabble_secuencial
    import double_dabble_pkg::*;
#(
    parameter int ANCHO   = 8,
    parameter int DIGITOS = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           inicio,
    input  logic [ANCHO-1:0]               X,
    output logic                           ocupado,
    output logic                           listo,
    output logic [ANCHO_DIGITO*DIGITOS-1:0] BCD,
    output logic                           desbordamiento
);

    localparam int ANCHO_BCD = ANCHO_DIGITO * DIGITOS;
    localparam int ANCHO_CNT = ancho_contador(ANCHO);

    estado_t              estado;
    estado_t              estado_sig;
    logic                 listo_sig;
    logic                 acepta;
    logic                 ultima;
    logic [ANCHO_CNT-1:0] contador;
    logic [ANCHO-1:0]     operando;
    logic [ANCHO_BCD-1:0] trabajo;
    logic [ANCHO_BCD-1:0] ajustado;
    logic [ANCHO_BCD-1:0] trabajo_sig;
    logic                 acumulador;
    logic                 bit_sale;

    for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
        ajuste_bcd_digito u_ajuste (
            .digito   (trabajo[g*ANCHO_DIGITO +: ANCHO_DIGITO]),
            .ajustado (ajustado[g*ANCHO_DIGITO +: ANCHO_DIGITO])
        );
    end

    // The top bit of the corrected top digit is dropped from the work register;
    // any 1 leaving there means the operand does not fit in DIGITOS digits.
    assign bit_sale    = ajustado[ANCHO_BCD-1];
    assign trabajo_sig = {ajustado[ANCHO_BCD-2:0], operando[ANCHO-1]};

    always_comb begin
        estado_sig = estado;
        listo_sig  = 1'b0;
        acepta     = 1'b0;
        ultima     = 1'b0;
        case (estado)
            REPOSO: begin
                if (inicio) begin
                    acepta     = 1'b1;
                    estado_sig = CONVIERTE;
                end
            end
            CONVIERTE: begin
                if (contador == ANCHO_CNT'(1)) begin
                    ultima     = 1'b1;
                    listo_sig  = 1'b1;
                    estado_sig = REPOSO;
                end
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= REPOSO;
            listo  <= 1'b0;
        end else begin
            estado <= estado_sig;
            listo  <= listo_sig;
        end
    end

    assign ocupado = (estado == CONVIERTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador       <= '0;
            operando       <= '0;
            trabajo        <= '0;
            acumulador     <= 1'b0;
            BCD            <= '0;
            desbordamiento <= 1'b0;
        end else if (acepta) begin
            contador   <= ANCHO_CNT'(ANCHO);
            operando   <= X;
            trabajo    <= '0;
            acumulador <= 1'b0;
        end else if (estado == CONVIERTE) begin
            contador   <= contador - ANCHO_CNT'(1);
            operando   <= {operando[ANCHO-2:0], 1'b0};
            trabajo    <= trabajo_sig;
            acumulador <= acumulador | bit_sale;
            // Outputs only ever take the finished value, never an intermediate one.
            if (ultima) begin
                BCD            <= trabajo_sig;
                desbordamiento <= acumulador | bit_sale;
            end
        end
    end

endmodule

// File: tb/tb_double_dabble_secuencial.sv
// Self-checking bench for double_dabble_secuencial in three configurations
// against a decimal-arithmetic reference model.
module tb_double_dabble_secuencial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  inicio_v = 3'b000;
    logic [15:0] x_bus = 16'd0;

    logic [2:0]  ocupado_v;
    logic [2:0]  listo_v;
    logic [2:0]  ovf_v;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [19:0] bcd_c;
    logic [19:0] bcd_v [3];

    int ancho_v   [3] = '{8, 8, 16};
    int digitos_v [3] = '{3, 2, 5};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    double_dabble_secuencial #(.ANCHO(8), .DIGITOS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .inicio(inicio_v[0]), .X(x_bus[7:0]),
        .ocupado(ocupado_v[0]), .listo(listo_v[0]), .BCD(bcd_a), .desbordamiento(ovf_v[0])
    );

    double_dabble_secuencial #(.ANCHO(8), .DIGITOS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .inicio(inicio_v[1]), .X(x_bus[7:0]),
        .ocupado(ocupado_v[1]), .listo(listo_v[1]), .BCD(bcd_b), .desbordamiento(ovf_v[1])
    );

    double_dabble_secuencial #(.ANCHO(16), .DIGITOS(5)) dut_c (
        .clk(clk), .rst_n(rst_n), .inicio(inicio_v[2]), .X(x_bus),
        .ocupado(ocupado_v[2]), .listo(listo_v[2]), .BCD(bcd_c), .desbordamiento(ovf_v[2])
    );

    assign bcd_v[0] = {8'd0, bcd_a};
    assign bcd_v[1] = {12'd0, bcd_b};
    assign bcd_v[2] = bcd_c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits of x modulo 10^dig, one nibble per digit.
    function automatic logic [19:0] ref_bcd(input longint x, input int dig);
        logic [19:0] r;
        longint v;
        r = '0;
        v = x;
        for (int i = 0; i < dig; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint x, input int dig);
        longint p;
        p = 1;
        for (int i = 0; i < dig; i++) p = p * 10;
        return (x >= p);
    endfunction

    // Runs one conversion; repulse >= 0 re-raises inicio in that busy cycle.
    task automatic convert(input int sel, input logic [15:0] x, input int repulse);
        int          n;
        int          extra;
        logic        cont;
        logic [19:0] exp_bcd;
        logic        exp_ovf;
        exp_bcd = ref_bcd(longint'(x), digitos_v[sel]);
        exp_ovf = ref_ovf(longint'(x), digitos_v[sel]);
        x_bus = x;
        inicio_v[sel] = 1'b1;
        tick();
        inicio_v[sel] = 1'b0;
        x_bus = 16'($urandom);
        n = 0;
        cont = 1'b1;
        while (listo_v[sel] !== 1'b1 && n < 64) begin
            if (ocupado_v[sel] !== 1'b1) cont = 1'b0;
            inicio_v[sel] = (n == repulse);
            tick();
            n++;
        end
        inicio_v[sel] = 1'b0;
        check("latencia", n, ancho_v[sel]);
        check("ocupado_continuo", cont, 1);
        check("ocupado_al_listo", ocupado_v[sel], 0);
        check("bcd", bcd_v[sel], exp_bcd);
        check("desbordamiento", ovf_v[sel], exp_ovf);
        tick();
        check("listo_un_ciclo", listo_v[sel], 0);
        if (repulse >= 0) begin
            extra = 0;
            repeat (2 * ancho_v[sel]) begin
                if (listo_v[sel] === 1'b1 || ocupado_v[sel] === 1'b1) extra++;
                tick();
            end
            check("inicio_ignorado", extra, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t_listo [$];
        logic [19:0] vals [$];
        logic [19:0] prev;
        int          bad;
        int          seen;
        int          gap;

        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            check("reset_ocupado", ocupado_v[s], 0);
            check("reset_listo", listo_v[s], 0);
            check("reset_bcd", bcd_v[s], 0);
            check("reset_desb", ovf_v[s], 0);
        end
        rst_n = 1'b1;
        tick();

        convert(0, 16'd255, -1);
        convert(0, 16'd0, -1);

        convert(1, 16'd200, -1);
        convert(1, 16'd99, -1);
        convert(1, 16'd100, -1);

        convert(2, 16'd65535, 5);

        // Back-to-back with inicio held high.
        bad = 0;
        prev = bcd_v[0];
        x_bus = 16'd12;
        inicio_v[0] = 1'b1;
        for (int c = 0; c < 40 && t_listo.size() < 2; c++) begin
            tick();
            if (listo_v[0] === 1'b1) begin
                t_listo.push_back(c);
                vals.push_back(bcd_v[0]);
                x_bus = 16'd34;
            end else if (bcd_v[0] !== prev) begin
                bad++;
            end
            prev = bcd_v[0];
        end
        inicio_v[0] = 1'b0;
        check("b2b_num_listo", t_listo.size(), 2);
        gap = (t_listo.size() == 2) ? (t_listo[1] - t_listo[0]) : -1;
        check("b2b_separacion", gap, ancho_v[0] + 1);
        check("b2b_primero", (vals.size() > 0) ? vals[0] : 20'hFFFFF, ref_bcd(12, 3));
        check("b2b_segundo", (vals.size() > 1) ? vals[1] : 20'hFFFFF, ref_bcd(34, 3));
        check("b2b_sin_intermedios", bad, 0);
        tick();

        // Reset in the middle of a conversion.
        x_bus = 16'd177;
        inicio_v[0] = 1'b1;
        tick();
        inicio_v[0] = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("abort_ocupado", ocupado_v[0], 0);
        check("abort_listo", listo_v[0], 0);
        check("abort_bcd", bcd_v[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (listo_v[0] === 1'b1) seen++;
        end
        check("abort_sin_listo", seen, 0);
        convert(0, 16'd177, -1);

        for (int v = 0; v < 256; v++) begin
            convert(0, 16'(v), -1);
        end

        for (int i = 0; i < 40; i++) begin
            convert(1, 16'($urandom_range(0, 255)), -1);
            convert(2, 16'($urandom_range(0, 65535)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
